bcm_plane_sequencer: RTL and testbench

- Sequences binary-code-modulation (BCM) brightness control for the LED driver path.
- For each bit plane: reads ROW_COUNT pixel words through a read handshake, latches them into the drivers, then holds the output enable for a weighted time of BASE_TICKS << plane.
- Drives the address pointer that feeds pixel memory.
- Emits operation_dn as the per-word advance pulse for downstream pointer logic.

---
 rtl/bcm_plane_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bcm_plane_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_plane_sequencer.sv
// BCM bit-plane sequencer: per plane, load ROW_COUNT words, latch them, then hold led_oe for BASE_TICKS << plane.
// Optional macro BCM_BLANK_EN inserts BLANK_TICKS blanking cycles between the final read and the latch strobe.
module bcm_plane_sequencer #(
    parameter  int PLANES      = 8,
    parameter  int ADDR_W      = 7,
    parameter  int ROW_COUNT   = 128,
    parameter  int BASE_TICKS  = 4,
    parameter  int BLANK_TICKS = 2,
    localparam int PSEL_W      = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] address,
    output logic [PSEL_W-1:0] plane_sel,
    output logic              operation_dn,
    output logic              latch,
    output logic              led_oe,
    output logic              frame_done,
    output logic              busy
);

    // One counter serves both the display hold and the blanking interval.
    localparam int DISP_MAX = BASE_TICKS << (PLANES - 1);
    localparam int CNT_MAX  = (DISP_MAX > BLANK_TICKS) ? DISP_MAX : BLANK_TICKS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROW_COUNT - 1);
    localparam logic [PSEL_W-1:0] LAST_PLANE = PSEL_W'(PLANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4,
        ST_NEXT    = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_address;
    logic [PSEL_W-1:0] r_plane_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rd_req;
    logic              r_latch;
    logic              r_led_oe;
    logic              r_frame_done;
    logic              r_busy;

    // Counter preload for the display hold of a plane (count runs down to zero).
    function automatic logic [CNT_W-1:0] disp_load(input logic [PSEL_W-1:0] plane);
        return (CNT_W'(BASE_TICKS) << plane) - CNT_W'(1);
    endfunction

    // Sequencer FSM; every output except operation_dn is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_plane_sel  <= '0;
            r_cnt        <= '0;
            r_rd_req     <= 1'b0;
            r_latch      <= 1'b0;
            r_led_oe     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_latch      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state  <= ST_LOAD;
                        r_rd_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (r_rd_req && rd_ack) begin
                        if (r_address == LAST_ADDR) begin
                            r_address <= '0;
                            r_rd_req  <= 1'b0;
`ifdef BCM_BLANK_EN
                            r_state   <= ST_BLANK;
                            r_cnt     <= CNT_W'(BLANK_TICKS - 1);
`else
                            r_state   <= ST_LATCH;
                            r_latch   <= 1'b1;
`endif
                        end else begin
                            r_address <= r_address + ADDR_W'(1);
                        end
                    end else begin
                        r_rd_req <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_LATCH;
                        r_latch <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    r_state  <= ST_DISPLAY;
                    r_led_oe <= 1'b1;
                    r_cnt    <= disp_load(r_plane_sel);
                end
                ST_DISPLAY: begin
                    if (r_cnt == '0) begin
                        r_state      <= ST_NEXT;
                        r_led_oe     <= 1'b0;
                        r_frame_done <= (r_plane_sel == LAST_PLANE);
                    end else begin
                        r_cnt        <= r_cnt - CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    // Enable is only honoured here at the frame boundary.
                    if (r_plane_sel != LAST_PLANE) begin
                        r_plane_sel <= r_plane_sel + PSEL_W'(1);
                        r_state     <= ST_LOAD;
                        r_rd_req    <= 1'b1;
                    end else begin
                        r_plane_sel <= '0;
                        if (enable) begin
                            r_state  <= ST_LOAD;
                            r_rd_req <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_address   <= '0;
                    r_plane_sel <= '0;
                    r_rd_req    <= 1'b0;
                    r_led_oe    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // The advance pulse must coincide with the accepting ack, so it is the only combinational output.
    assign operation_dn = r_rd_req & rd_ack;
    assign rd_req       = r_rd_req;
    assign address      = r_address;
    assign plane_sel    = r_plane_sel;
    assign latch        = r_latch;
    assign led_oe       = r_led_oe;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;

endmodule

// File: tb/tb_bcm_plane_sequencer.sv
// Scoreboard bench for bcm_plane_sequencer (PLANES=3, ADDR_W=2, ROW_COUNT=4, BASE_TICKS=2).
module tb_bcm_plane_sequencer;

    localparam int PLANES      = 3;
    localparam int ADDR_W      = 2;
    localparam int ROW_COUNT   = 4;
    localparam int BASE_TICKS  = 2;
    localparam int BLANK_TICKS = 2;
`ifdef BCM_BLANK_EN
    localparam int BLANK_EXP   = BLANK_TICKS;
`else
    localparam int BLANK_EXP   = 0;
`endif
    localparam int FRAME_LEN = PLANES * (ROW_COUNT + 2) + BASE_TICKS * ((1 << PLANES) - 1)
                               + PLANES * BLANK_EXP;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              rd_ack = 1'b1;
    logic              rd_req;
    logic [ADDR_W-1:0] address;
    logic [1:0]        plane_sel;
    logic              operation_dn, latch, led_oe, frame_done, busy;

    bcm_plane_sequencer #(
        .PLANES(PLANES), .ADDR_W(ADDR_W), .ROW_COUNT(ROW_COUNT),
        .BASE_TICKS(BASE_TICKS), .BLANK_TICKS(BLANK_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rd_req(rd_req), .rd_ack(rd_ack),
        .address(address), .plane_sel(plane_sel), .operation_dn(operation_dn),
        .latch(latch), .led_oe(led_oe), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int disp_q[$];
    int frame_q[$];
    int fd_count = 0;
    logic ack_toggle = 1'b0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic push_frame(input int flen);
        for (int p = 0; p < PLANES; p++) begin
            for (int a = 0; a < ROW_COUNT; a++) exp_q.push_back(p * 256 + a);
            disp_q.push_back(BASE_TICKS << p);
        end
        frame_q.push_back(flen);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ack_toggle) rd_ack = ~rd_ack;
    endtask

    task automatic wait_fd(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, int'(done), 1);
    endtask

    // Monitor: pops expectations as the DUT produces operation_dn, led_oe runs and frame_done.
    initial begin
        int e, flen, ops, gap, oe_run;
        bit in_frame, armed, p_req, p_ack, p_fd;
        logic [ADDR_W-1:0] p_addr;
        flen = 0; ops = 0; gap = 0; oe_run = 0;
        in_frame = 0; armed = 0; p_req = 0; p_ack = 0; p_fd = 0; p_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0; armed = 0; ops = 0; gap = 0; oe_run = 0;
                p_req = 0; p_ack = 0; p_fd = 0;
            end else begin
                chk("oe_overlap", int'(led_oe & (latch | rd_req)), 0);
                if (p_req) begin
                    if (p_ack && p_addr == ADDR_W'(ROW_COUNT - 1)) chk("req_drop", int'(rd_req), 0);
                    else chk("req_hold", int'(rd_req), 1);
                    if (!p_ack) chk("addr_hold", int'(address), int'(p_addr));
                end
                if (p_fd) chk("fd_pulse", int'(frame_done), 0);
                if (operation_dn) begin
                    chk("op_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("op_plane_addr", int'(plane_sel) * 256 + int'(address), e);
                    end
                    ops++; armed = 1; gap = 0;
                end else if (latch) begin
                    if (armed) chk("blank_gap", gap, BLANK_EXP);
                    chk("ops_per_plane", ops, ROW_COUNT);
                    armed = 0; ops = 0;
                end else if (armed) begin
                    gap++;
                end
                if (led_oe) begin
                    oe_run++;
                end else if (oe_run != 0) begin
                    chk("oe_expected", int'(disp_q.size() != 0), 1);
                    if (disp_q.size() != 0) begin
                        e = disp_q.pop_front();
                        chk("oe_len", oe_run, e);
                    end
                    oe_run = 0;
                end
                if (!in_frame && rd_req) begin
                    in_frame = 1; flen = 0;
                end
                if (in_frame) flen++;
                if (frame_done) begin
                    fd_count++; in_frame = 0;
                    if (frame_q.size() != 0) begin
                        e = frame_q.pop_front();
                        if (e != 0) chk("frame_len", flen, e);
                    end
                end
                p_req = rd_req; p_ack = rd_ack; p_addr = address; p_fd = frame_done;
            end
        end
    end

    // Driver.
    initial begin
        bit ok;
        int fd0;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({rd_req, latch, led_oe, frame_done, operation_dn}), 0);
        chk("rst_addr_plane", int'({plane_sel, address}), 0);
        rst = 1'b0;
        step();

        // Back-to-back frames with continuous ack.
        push_frame(FRAME_LEN);
        push_frame(FRAME_LEN);
        enable = 1'b1;
        chk("lat_before", int'(rd_req), 0);
        step();
        chk("lat_rd_req", int'(rd_req), 1);
        wait_fd("fd1", 200);
        step();
        chk("b2b_rd_req", int'(rd_req), 1);
        chk("b2b_addr_plane", int'({plane_sel, address}), 0);
        enable = 1'b0;
        wait_fd("fd2", 200);
        step(); step();
        chk("idle_busy", int'(busy), 0);

        // Ack toggling every cycle.
        push_frame(0);
        ack_toggle = 1'b1;
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_fd("fd_stall", 400);
        ack_toggle = 1'b0;
        rd_ack = 1'b1;
        step(); step();

        // Enable dropped during plane 1 display.
        push_frame(FRAME_LEN);
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (plane_sel == 2'd1 && led_oe) begin ok = 1'b1; break; end
        end
        chk("reach_p1_oe", int'(ok), 1);
        enable = 1'b0;
        fd0 = fd_count;
        wait_fd("fd_drop", 200);
        repeat (5) step();
        chk("drop_fd_once", fd_count - fd0, 1);
        chk("drop_busy", int'(busy), 0);
        chk("drop_addr", int'(address), 0);
        chk("drop_q_drained", exp_q.size() + disp_q.size() + frame_q.size(), 0);

        // Reset in LOAD at address 2, then restart.
        push_frame(FRAME_LEN);
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (rd_req && address == 2'd2) begin ok = 1'b1; break; end
        end
        chk("reach_addr2", int'(ok), 1);
        rst = 1'b1;
        enable = 1'b0;
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_outs", int'({rd_req, latch, led_oe, frame_done, operation_dn}), 0);
        chk("abort_addr_plane", int'({plane_sel, address}), 0);
        exp_q.delete(); disp_q.delete(); frame_q.delete();
        rst = 1'b0;
        push_frame(FRAME_LEN);
        enable = 1'b1;
        step();
        chk("restart_rd_req", int'(rd_req), 1);
        chk("restart_addr_plane", int'({plane_sel, address}), 0);
        enable = 1'b0;
        wait_fd("fd_restart", 200);
        repeat (3) step();
        chk("end_busy", int'(busy), 0);
        chk("end_q_drained", exp_q.size() + disp_q.size() + frame_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
